// File: rtl/cfu_cmd_sequencer.sv
// Host-side CFU initiator: queues (function_id, operand) jobs, issues them to
// the CFU one at a time and returns each response or a timeout error in order.
module cfu_cmd_sequencer #(
  parameter int DEPTH   = 8,
  parameter int FUNCT_W = 10,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               job_valid,
  output logic               job_ready,
  input  logic [FUNCT_W-1:0] job_function_id,
  input  logic [DATA_W-1:0]  job_operand,
  output logic               cmd_valid,
  input  logic               cmd_ready,
  output logic [FUNCT_W-1:0] cmd_payload_function_id,
  output logic [DATA_W-1:0]  cmd_payload_inputs_0,
  input  logic               rsp_valid,
  output logic               rsp_ready,
  input  logic [DATA_W-1:0]  rsp_payload_outputs_0,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [DATA_W-1:0]  res_data,
  output logic               res_error,
  output logic               busy,
  output logic [7:0]         stray_cnt
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int EW = FUNCT_W + DATA_W;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_RSP,
    ST_HOLD
  } state_t;

  state_t              state_q, state_d;
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]       count_q, count_d;
  logic                cmd_valid_q, cmd_valid_d;
  logic [FUNCT_W-1:0]  cmd_fid_q, cmd_fid_d;
  logic [DATA_W-1:0]   cmd_data_q, cmd_data_d;
  logic                res_valid_q, res_valid_d;
  logic [DATA_W-1:0]   res_data_q, res_data_d;
  logic                res_error_q, res_error_d;
  logic [TW-1:0]       tmo_q, tmo_d;
  logic [7:0]          stray_q, stray_d;

  logic                push;
  logic                pop;
  logic                rsp_fire;
  logic                stray_hit;
  logic [EW-1:0]       head;
  logic [EW-1:0]       mem_q [DEPTH];

  // Full is derived from the registered count, so a pop never frees a slot
  // for a push in the same cycle.
  assign job_ready = (count_q != FULL_CNT);
  assign push      = job_valid && job_ready;
  assign rsp_ready = (state_q != ST_HOLD);
  assign rsp_fire  = rsp_valid && rsp_ready;
  assign head      = mem_q[rd_ptr_q];

  assign cmd_valid               = cmd_valid_q;
  assign cmd_payload_function_id = cmd_fid_q;
  assign cmd_payload_inputs_0    = cmd_data_q;
  assign res_valid               = res_valid_q;
  assign res_data                = res_data_q;
  assign res_error               = res_error_q;
  assign stray_cnt               = stray_q;
  assign busy                    = (state_q != ST_IDLE) || (count_q != '0);

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {job_function_id, job_operand};
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    pop         = 1'b0;
    stray_hit   = 1'b0;
    cmd_valid_d = cmd_valid_q;
    cmd_fid_d   = cmd_fid_q;
    cmd_data_d  = cmd_data_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_error_d = res_error_q;
    tmo_d       = tmo_q;

    case (state_q)
      ST_IDLE: begin
        stray_hit = rsp_fire;
        if (count_q != '0) begin
          pop         = 1'b1;
          cmd_valid_d = 1'b1;
          cmd_fid_d   = head[EW-1:DATA_W];
          cmd_data_d  = head[DATA_W-1:0];
          state_d     = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        if (cmd_ready) begin
          cmd_valid_d = 1'b0;
          tmo_d       = '0;
          // A CFU that answers combinationally completes in the accept cycle.
          if (rsp_valid) begin
            res_valid_d = 1'b1;
            res_data_d  = rsp_payload_outputs_0;
            res_error_d = 1'b0;
            state_d     = ST_HOLD;
          end else begin
            state_d     = ST_WAIT_RSP;
          end
        end else begin
          stray_hit = rsp_fire;
        end
      end

      ST_WAIT_RSP: begin
        if (rsp_fire) begin
          res_valid_d = 1'b1;
          res_data_d  = rsp_payload_outputs_0;
          res_error_d = 1'b0;
          state_d     = ST_HOLD;
        end else if (tmo_q == TMO_LAST) begin
          res_valid_d = 1'b1;
          res_data_d  = '0;
          res_error_d = 1'b1;
          state_d     = ST_HOLD;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end

      ST_HOLD: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    stray_d = stray_q;
    if (stray_hit && (stray_q != 8'hFF)) begin
      stray_d = stray_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      cmd_valid_q <= 1'b0;
      cmd_fid_q   <= '0;
      cmd_data_q  <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_error_q <= 1'b0;
      tmo_q       <= '0;
      stray_q     <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_fid_q   <= cmd_fid_d;
      cmd_data_q  <= cmd_data_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_error_q <= res_error_d;
      tmo_q       <= tmo_d;
      stray_q     <= stray_d;
    end
  end

endmodule

// File: tb/tb_cfu_cmd_sequencer.sv
// Bench for cfu_cmd_sequencer: directed scenarios plus a random stream, with a
// job-order scoreboard and a simple CFU responder model.
module tb_cfu_cmd_sequencer;

  localparam int FW    = 10;
  localparam int DW    = 32;
  localparam int DEPTH = 8;
  localparam int TMO   = 16;

  typedef struct packed {
    logic [FW-1:0] fid;
    logic [DW-1:0] op;
  } job_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          job_valid = 1'b0;
  logic          job_ready;
  logic [FW-1:0] job_function_id = '0;
  logic [DW-1:0] job_operand = '0;
  logic          cmd_valid;
  logic          cmd_ready = 1'b0;
  logic [FW-1:0] cmd_payload_function_id;
  logic [DW-1:0] cmd_payload_inputs_0;
  logic          rsp_valid = 1'b0;
  logic          rsp_ready;
  logic [DW-1:0] rsp_payload_outputs_0 = '0;
  logic          res_valid;
  logic          res_ready = 1'b0;
  logic [DW-1:0] res_data;
  logic          res_error;
  logic          busy;
  logic [7:0]    stray_cnt;

  always #5 clk = ~clk;

  cfu_cmd_sequencer #(
    .DEPTH(DEPTH), .FUNCT_W(FW), .DATA_W(DW), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .reset(reset),
    .job_valid(job_valid), .job_ready(job_ready),
    .job_function_id(job_function_id), .job_operand(job_operand),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_payload_function_id(cmd_payload_function_id),
    .cmd_payload_inputs_0(cmd_payload_inputs_0),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_payload_outputs_0(rsp_payload_outputs_0),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_error(res_error),
    .busy(busy), .stray_cnt(stray_cnt)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: jobs still to offer, jobs accepted but not yet
  // commanded, and results owed to the consumer, all in job order.
  job_t          stim_q[$];
  job_t          exp_cmd_q[$];
  logic [DW:0]   exp_res_q[$];

  int            cr_pct = 100, rr_pct = 100, jv_pct = 100;
  bit            silent = 0, same = 0, rand_lat = 0;
  int            cfu_lat = 3;
  logic [DW-1:0] same_val = '0;
  bit            cfu_pend = 0;
  int            cfu_wait = 0;
  logic [DW-1:0] cfu_op = '0;

  int            cyc = 0, n_cmd = 0, n_res = 0, acc_cyc = 0, res_cyc = 0;
  bit            res_prev = 0;
  bit            cmd_stall = 0, res_stall = 0;
  job_t          cmd_saved;
  logic [DW:0]   res_saved;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    bit   pf, cf, rf, sf;
    job_t j;
    @(negedge clk);
    pf = job_valid && job_ready;
    cf = cmd_valid && cmd_ready;
    rf = rsp_valid && rsp_ready;
    sf = res_valid && res_ready;
    if (reset) begin
      pf = 0; cf = 0; rf = 0; sf = 0;
      cmd_stall = 0; res_stall = 0;
    end else begin
      if (cmd_stall) begin
        check("cmd_hold_valid", cmd_valid, 1'b1);
        check("cmd_hold_payload", {cmd_payload_function_id, cmd_payload_inputs_0}, cmd_saved);
      end
      if (res_stall) begin
        check("res_hold_valid", res_valid, 1'b1);
        check("res_hold_data", {res_error, res_data}, res_saved);
      end
      if (pf) exp_cmd_q.push_back({job_function_id, job_operand});
      if (cf) begin
        n_cmd++;
        acc_cyc = cyc + 1;
        check("cmd_expected_pending", exp_cmd_q.size() != 0, 1'b1);
        if (exp_cmd_q.size() != 0) begin
          j = exp_cmd_q.pop_front();
          check("cmd_payload", {cmd_payload_function_id, cmd_payload_inputs_0}, j);
          if (same)        exp_res_q.push_back({1'b0, same_val});
          else if (silent) exp_res_q.push_back({1'b1, {DW{1'b0}}});
          else begin
            exp_res_q.push_back({1'b0, DW'(j.op + 1)});
            cfu_pend = 1;
            cfu_wait = rand_lat ? int'($urandom_range(1, 5)) : cfu_lat;
            cfu_op   = j.op;
          end
        end
      end
      if (sf) begin
        n_res++;
        check("res_expected_pending", exp_res_q.size() != 0, 1'b1);
        if (exp_res_q.size() != 0) check("res_value", {res_error, res_data}, exp_res_q.pop_front());
      end
      cmd_stall = cmd_valid && !cmd_ready;
      cmd_saved = {cmd_payload_function_id, cmd_payload_inputs_0};
      res_stall = res_valid && !res_ready;
      res_saved = {res_error, res_data};
    end
    @(posedge clk);
    #1;
    cyc++;
    if (!res_prev && res_valid) res_cyc = cyc;
    res_prev = res_valid;
    if (pf) void'(stim_q.pop_front());
    job_valid = (stim_q.size() > 0) && ($urandom_range(0, 99) < jv_pct);
    if (stim_q.size() > 0) {job_function_id, job_operand} = stim_q[0];
    if (same) begin
      cmd_ready             = cmd_valid;
      rsp_valid             = cmd_valid;
      rsp_payload_outputs_0 = same_val;
    end else begin
      cmd_ready = ($urandom_range(0, 99) < cr_pct);
      if (rf) begin
        rsp_valid = 0;
        cfu_pend  = 0;
      end
      if (cfu_pend && !rsp_valid) begin
        if (cfu_wait <= 1) begin
          rsp_valid             = 1;
          rsp_payload_outputs_0 = cfu_op + 1;
        end else begin
          cfu_wait--;
        end
      end
    end
    res_ready = ($urandom_range(0, 99) < rr_pct);
  endtask

  task automatic run_until_idle(input int max_cyc, input string tag);
    int  k;
    bit  done;
    k = 0;
    done = 0;
    while (!done && k < max_cyc) begin
      tick();
      k++;
      done = (stim_q.size() == 0) && (exp_cmd_q.size() == 0) &&
             (exp_res_q.size() == 0) && !busy && !res_valid;
    end
    check(tag, done, 1'b1);
  endtask

  initial begin
    int   k, c0, r0;
    job_t jb;

    // Reset values while reset is held
    repeat (3) @(posedge clk);
    #1;
    check("rst_cmd_valid", cmd_valid, 1'b0);
    check("rst_cmd_fid", cmd_payload_function_id, '0);
    check("rst_cmd_data", cmd_payload_inputs_0, '0);
    check("rst_res_valid", res_valid, 1'b0);
    check("rst_res_data", res_data, '0);
    check("rst_res_error", res_error, 1'b0);
    check("rst_stray", stray_cnt, '0);
    check("rst_busy", busy, 1'b0);
    reset = 0;
    #1;
    check("rst_job_ready", job_ready, 1'b1);
    check("rst_rsp_ready", rsp_ready, 1'b1);

    // Single job, CFU answers operand+1 three cycles after accept
    c0 = n_cmd; r0 = n_res;
    stim_q.push_back('{fid: 10'd1, op: 32'h00cccccd});
    tick();
    tick();
    check("single_cmd_before", cmd_valid, 1'b0);
    tick();
    check("single_cmd_after", cmd_valid, 1'b1);
    run_until_idle(100, "single_done");
    check("single_cmd_count", n_cmd - c0, 1);
    check("single_res_count", n_res - r0, 1);

    // Back-pressure on both command and result sides
    cr_pct = 0; rr_pct = 0; r0 = n_res;
    stim_q.push_back('{fid: 10'd2, op: 32'h000a3d71});
    k = 0;
    while (!cmd_valid && k < 20) begin tick(); k++; end
    check("bp_cmd_seen", cmd_valid, 1'b1);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_cmd_valid", cmd_valid, 1'b1);
      check("bp_cmd_data", cmd_payload_inputs_0, 32'h000a3d71);
    end
    cr_pct = 100;
    k = 0;
    while (!res_valid && k < 30) begin tick(); k++; end
    check("bp_res_seen", res_valid, 1'b1);
    for (int i = 0; i < 4; i++) begin
      check("bp_rsp_ready_hold", rsp_ready, 1'b0);
      check("bp_res_data", res_data, 32'h000a3d72);
      tick();
    end
    rr_pct = 100;
    run_until_idle(50, "bp_done");
    check("bp_res_count", n_res - r0, 1);

    // Random stream against the in-order model
    cr_pct = 70; rr_pct = 70; jv_pct = 70; rand_lat = 1; r0 = n_res;
    for (int i = 0; i < 40; i++) begin
      jb.fid = FW'($urandom_range(0, 1023));
      jb.op  = $urandom;
      stim_q.push_back(jb);
    end
    run_until_idle(3000, "rand_done");
    check("rand_res_count", n_res - r0, 40);
    cr_pct = 100; rr_pct = 100; jv_pct = 100; rand_lat = 0;

    // Full FIFO: one blocker stuck in ISSUE, then fill all 8 entries
    cr_pct = 0; r0 = n_res;
    stim_q.push_back('{fid: 10'd3, op: 32'hffff0000});
    k = 0;
    while (!cmd_valid && k < 20) begin tick(); k++; end
    for (int i = 0; i < 9; i++) stim_q.push_back('{fid: 10'd4, op: DW'(i)});
    k = 0;
    while (stim_q.size() > 1 && k < 40) begin tick(); k++; end
    check("full_accepted", stim_q.size(), 1);
    check("full_job_ready", job_ready, 1'b0);
    repeat (3) tick();
    check("full_ninth_held", stim_q.size(), 1);
    check("full_job_ready_held", job_ready, 1'b0);
    check("full_busy", busy, 1'b1);
    cr_pct = 100;
    run_until_idle(500, "full_done");
    check("full_res_count", n_res - r0, 10);

    // Timeout: CFU never answers
    silent = 1; c0 = n_cmd;
    stim_q.push_back('{fid: 10'd5, op: 32'h12345678});
    k = 0;
    while (n_cmd == c0 && k < 20) begin tick(); k++; end
    k = 0;
    while (!res_valid && k < 40) begin tick(); k++; end
    check("tmo_res_valid", res_valid, 1'b1);
    check("tmo_latency", res_cyc - acc_cyc, TMO);
    check("tmo_res_error", res_error, 1'b1);
    check("tmo_res_data", res_data, '0);
    run_until_idle(50, "tmo_done");
    silent = 0;

    // Late response in IDLE is a stray
    r0 = n_res;
    rsp_valid = 1; rsp_payload_outputs_0 = 32'hdead0001;
    tick();
    check("stray_count", stray_cnt, 8'd1);
    repeat (3) tick();
    check("stray_no_result", res_valid, 1'b0);
    check("stray_res_count", n_res - r0, 0);

    // Response in the same cycle as command accept skips WAIT_RSP
    same = 1; same_val = 32'h0bbad960; c0 = n_cmd;
    stim_q.push_back('{fid: 10'd6, op: 32'h00000042});
    k = 0;
    while (n_cmd == c0 && k < 20) begin tick(); k++; end
    check("same_res_valid", res_valid, 1'b1);
    check("same_latency", res_cyc - acc_cyc, 0);
    check("same_res_data", res_data, 32'h0bbad960);
    run_until_idle(50, "same_done");
    same = 0;

    // Asynchronous reset in WAIT_RSP with 3 jobs queued
    cfu_lat = 8; c0 = n_cmd;
    for (int i = 0; i < 4; i++) stim_q.push_back('{fid: 10'd7, op: DW'(100 + i)});
    k = 0;
    while ((n_cmd == c0 || stim_q.size() != 0) && k < 30) begin tick(); k++; end
    tick();
    check("arst_busy_before", busy, 1'b1);
    #2 reset = 1;
    #1;
    check("arst_cmd_valid", cmd_valid, 1'b0);
    check("arst_cmd_fid", cmd_payload_function_id, '0);
    check("arst_cmd_data", cmd_payload_inputs_0, '0);
    check("arst_res_valid", res_valid, 1'b0);
    check("arst_res_data", res_data, '0);
    check("arst_res_error", res_error, 1'b0);
    check("arst_stray", stray_cnt, '0);
    check("arst_busy", busy, 1'b0);
    stim_q.delete(); exp_cmd_q.delete(); exp_res_q.delete();
    job_valid = 0;
    tick();
    reset = 0;
    c0 = n_cmd;
    repeat (15) tick();
    check("arst_no_cmds", n_cmd - c0, 0);
    check("arst_late_stray", stray_cnt, 8'd1);
    check("arst_idle", busy, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
